// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter slice.
//   src_e       : requester ID carried through the outstanding-ID FIFO
//   sram_size_e : SRAM-like size encoding (bytes = 1 << size)
package sram_port_arbiter_pkg;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } sram_size_e;

endpackage

// File: rtl/ot_id_fifo.sv
// In-order FIFO of requester IDs for accepted-but-unanswered requests.
//   clk, reset  : clock, synchronous active-high reset (empties the FIFO)
//   push_i      : enqueue push_id_i (ignored when full)
//   pop_i       : dequeue head (ignored when empty)
//   full_o      : DEPTH entries held
//   empty_o     : no entries held
//   head_o      : oldest ID, valid when !empty_o
module ot_id_fifo
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  src_e push_id_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output src_e head_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  src_e          mem_q [DEPTH];
  logic          do_push, do_pop;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    full_o  = (cnt_q == CW'(DEPTH));
    empty_o = (cnt_q == '0);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wr_d    = wr_q + PW'(do_push);
    rd_d    = rd_q + PW'(do_pop);
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    head_o  = mem_q[rd_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_id_i;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between instruction fetch (inst_*) and
// load/store (data_*). Data has priority; a grant is held until its address
// handshake completes; an in-order ID FIFO routes each response back.
//   clk, reset                  : clock, synchronous active-high reset
//   inst_* / data_* (in)        : req, wr, size, wstrb, addr, wdata
//   inst_* / data_* (out)       : addr_ok, data_ok, rdata
//   mem_* (out)                 : req, wr, size, wstrb, addr, wdata
//   mem_addr_ok/data_ok/rdata   : shared port handshake and read data
//   proto_err                   : sticky, response seen with no outstanding ID
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned OT_DEPTH = 4,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_req,
  input  logic            inst_wr,
  input  logic [1:0]      inst_size,
  input  logic [DW/8-1:0] inst_wstrb,
  input  logic [AW-1:0]   inst_addr,
  input  logic [DW-1:0]   inst_wdata,
  output logic            inst_addr_ok,
  output logic            inst_data_ok,
  output logic [DW-1:0]   inst_rdata,
  input  logic            data_req,
  input  logic            data_wr,
  input  logic [1:0]      data_size,
  input  logic [DW/8-1:0] data_wstrb,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  output logic            data_addr_ok,
  output logic            data_data_ok,
  output logic [DW-1:0]   data_rdata,
  output logic            mem_req,
  output logic            mem_wr,
  output logic [1:0]      mem_size,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_addr_ok,
  input  logic            mem_data_ok,
  input  logic [DW-1:0]   mem_rdata,
  output logic            proto_err
);

  logic lock_q, lock_d;
  src_e lock_id_q, lock_id_d;
  logic proto_err_q, proto_err_d;

  src_e grant;
  logic gnt_req, issue, pop;
  logic fifo_full, fifo_empty;
  src_e fifo_head;

  always_comb begin
    grant   = lock_q ? lock_id_q : (data_req ? SRC_DATA : SRC_INST);
    gnt_req = (grant == SRC_DATA) ? data_req : inst_req;
    // Full is judged on the registered count: a same-cycle pop does not free a slot.
    mem_req = gnt_req && !fifo_full && !reset;
    issue   = mem_req && mem_addr_ok;

    if (grant == SRC_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else begin
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_wstrb = inst_wstrb;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end

    inst_addr_ok = issue && (grant == SRC_INST);
    data_addr_ok = issue && (grant == SRC_DATA);

    pop          = mem_data_ok && !fifo_empty && !reset;
    inst_data_ok = pop && (fifo_head == SRC_INST);
    data_data_ok = pop && (fifo_head == SRC_DATA);
    inst_rdata   = inst_data_ok ? mem_rdata : '0;
    data_rdata   = data_data_ok ? mem_rdata : '0;

    // Lock holds across full stalls because it only changes while mem_req is up.
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (mem_req) begin
      if (mem_addr_ok) begin
        lock_d = 1'b0;
      end else begin
        lock_d    = 1'b1;
        lock_id_d = grant;
      end
    end

    proto_err_d = proto_err_q || (mem_data_ok && fifo_empty);
    proto_err   = proto_err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q      <= 1'b0;
      lock_id_q   <= SRC_INST;
      proto_err_q <= 1'b0;
    end else begin
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
      proto_err_q <= proto_err_d;
    end
  end

  ot_id_fifo #(
    .DEPTH (OT_DEPTH)
  ) u_ot_id_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (issue),
    .push_id_i (grant),
    .pop_i     (pop),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_o    (fifo_head)
  );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a queue-based reference model
// checked on every falling edge, plus literal expectations per scenario.
module tb_sram_port_arbiter;

  localparam int unsigned OT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, proto_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .OT_DEPTH (OT),
    .AW       (32),
    .DW       (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_wstrb   (inst_wstrb),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
    .proto_err    (proto_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of outstanding owners (1=data), held owner while
  // an address phase is pending, sticky error flag.
  bit mq[$];
  bit m_held  = 1'b0;
  bit m_owner = 1'b0;
  bit m_err   = 1'b0;

  always @(negedge clk) begin
    bit          full, owner, req, e_req, e_iss, e_pop, head;
    logic [31:0] e_addr;
    logic [38:0] e_ctl, a_ctl;
    full   = (mq.size() == OT);
    owner  = m_held ? m_owner : data_req;
    req    = owner ? data_req : inst_req;
    e_req  = req && !full && !reset;
    e_iss  = e_req && mem_addr_ok;
    e_pop  = mem_data_ok && (mq.size() != 0) && !reset;
    head   = (mq.size() != 0) ? mq[0] : 1'b0;
    chk("mem_req", 64'(mem_req), 64'(e_req));
    chk("inst_addr_ok", 64'(inst_addr_ok), 64'(e_iss && !owner));
    chk("data_addr_ok", 64'(data_addr_ok), 64'(e_iss && owner));
    chk("inst_data_ok", 64'(inst_data_ok), 64'(e_pop && !head));
    chk("data_data_ok", 64'(data_data_ok), 64'(e_pop && head));
    chk("inst_rdata", 64'(inst_rdata), 64'((e_pop && !head) ? mem_rdata : 32'h0));
    chk("data_rdata", 64'(data_rdata), 64'((e_pop && head) ? mem_rdata : 32'h0));
    if (e_req) begin
      e_addr = owner ? data_addr : inst_addr;
      e_ctl  = owner ? {data_wr, data_size, data_wstrb, data_wdata}
                     : {inst_wr, inst_size, inst_wstrb, inst_wdata};
      a_ctl  = {mem_wr, mem_size, mem_wstrb, mem_wdata};
      chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      chk("mem_ctl", 64'(a_ctl), 64'(e_ctl));
    end
    if (!reset) chk("proto_err", 64'(proto_err), 64'(m_err));

    if (reset) begin
      mq.delete();
      m_held = 1'b0;
      m_err  = 1'b0;
    end else begin
      if (mem_data_ok && mq.size() == 0) m_err = 1'b1;
      if (e_pop) void'(mq.pop_front());
      if (e_iss) mq.push_back(owner);
      if (e_req) begin
        m_held  = !mem_addr_ok;
        m_owner = owner;
      end
    end
  end

  task automatic step(input bit ir, input bit dr, input bit aok, input bit dok,
                      input logic [31:0] rd);
    @(posedge clk);
    #1;
    inst_req    = ir;
    data_req    = dr;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rd;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ni, nd, outn, idok, ddok;
    bit ir, dr, dpend, aok, dok;

    reset = 1'b1;
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    inst_addr = 32'h1c00_0000; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hf;
    inst_wdata = 32'h0;
    data_addr = 32'h8000_0010; data_wr = 1; data_size = 2'd1; data_wstrb = 4'h3;
    data_wdata = 32'hdead_beef;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #2;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);

    // 1: single fetch
    step(1, 0, 1, 0, 0);
    #2;
    chk("t1_inst_addr_ok", 64'(inst_addr_ok), 64'd1);
    chk("t1_mem_addr", 64'(mem_addr), 64'h1c00_0000);
    step(0, 0, 0, 1, 32'h0280_0000);
    #2;
    chk("t1_inst_data_ok", 64'(inst_data_ok), 64'd1);
    chk("t1_inst_rdata", 64'(inst_rdata), 64'h0280_0000);
    chk("t1_data_data_ok", 64'(data_data_ok), 64'd0);

    // 2: simultaneous requests, data first
    step(1, 1, 1, 0, 0);
    #2;
    chk("t2_data_addr_ok", 64'(data_addr_ok), 64'd1);
    chk("t2_inst_addr_ok0", 64'(inst_addr_ok), 64'd0);
    chk("t2_mem_wr", 64'(mem_wr), 64'd1);
    step(1, 0, 1, 1, 32'h0000_1111);
    #2;
    chk("t2_data_data_ok", 64'(data_data_ok), 64'd1);
    chk("t2_data_rdata", 64'(data_rdata), 64'h1111);
    chk("t2_inst_addr_ok1", 64'(inst_addr_ok), 64'd1);
    step(0, 0, 0, 1, 32'h0000_2222);
    #2;
    chk("t2_inst_data_ok", 64'(inst_data_ok), 64'd1);
    chk("t2_inst_rdata", 64'(inst_rdata), 64'h2222);

    // 3: inst address phase stalled while data rises
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    #2 chk("t3_hold_addr_a", 64'(mem_addr), 64'h1c00_0000);
    step(1, 1, 0, 0, 0);
    #2 chk("t3_hold_addr_b", 64'(mem_addr), 64'h1c00_0000);
    step(1, 1, 1, 0, 0);
    #2;
    chk("t3_inst_addr_ok", 64'(inst_addr_ok), 64'd1);
    chk("t3_data_addr_ok0", 64'(data_addr_ok), 64'd0);
    step(0, 1, 1, 0, 0);
    #2;
    chk("t3_data_addr_ok", 64'(data_addr_ok), 64'd1);
    chk("t3_data_addr", 64'(mem_addr), 64'h8000_0010);
    step(0, 0, 0, 1, 32'h3);
    #2 chk("t3_resp_inst", 64'(inst_data_ok), 64'd1);
    step(0, 0, 0, 1, 32'h4);
    #2 chk("t3_resp_data", 64'(data_data_ok), 64'd1);

    // 4: full gating, no bypass on same-cycle pop
    repeat (4) step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    #2;
    chk("t4_full_req", 64'(mem_req), 64'd0);
    chk("t4_full_aok", 64'(inst_addr_ok), 64'd0);
    step(1, 0, 1, 1, 32'h33);
    #2;
    chk("t4_pop_no_bypass", 64'(mem_req), 64'd0);
    chk("t4_pop_dok", 64'(inst_data_ok), 64'd1);
    step(1, 0, 1, 0, 0);
    #2;
    chk("t4_reissue", 64'(mem_req), 64'd1);
    chk("t4_reissue_aok", 64'(inst_addr_ok), 64'd1);
    repeat (4) step(0, 0, 0, 1, 32'h40);

    // 5: interleaved traffic with random handshake delays
    ni = 3; nd = 3; outn = 0; idok = 0; ddok = 0; dpend = 0;
    for (int c = 0; c < 80 && (ni > 0 || nd > 0 || outn > 0); c++) begin
      ir  = (ni > 0);
      dr  = (nd > 0) && (dpend || (c % 3 != 1));
      aok = 1'($urandom_range(0, 1));
      dok = (outn > 0) && (1'($urandom_range(0, 1)));
      step(ir, dr, aok, dok, 32'h5000_0000 + 32'(c));
      #2;
      if (inst_addr_ok) ni--;
      if (data_addr_ok) nd--;
      dpend = dr && !data_addr_ok;
      idok += int'(inst_data_ok);
      ddok += int'(data_data_ok);
      outn += int'(inst_addr_ok) + int'(data_addr_ok) - int'(dok);
    end
    chk("t5_inst_responses", 64'(idok), 64'd3);
    chk("t5_data_responses", 64'(ddok), 64'd3);
    chk("t5_all_issued", 64'(ni + nd), 64'd0);

    // 6: protocol error and mid-flight reset
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    #2 chk("t6_proto_err_set", 64'(proto_err), 64'd1);
    step(0, 0, 0, 0, 0);
    #2 chk("t6_proto_err_sticky", 64'(proto_err), 64'd1);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1; inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #2;
    chk("t6_rst_mem_req", 64'(mem_req), 64'd0);
    chk("t6_rst_inst_dok", 64'(inst_data_ok), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0; data_req = 1; mem_addr_ok = 0; mem_data_ok = 0;
    #2;
    chk("t6_err_cleared", 64'(proto_err), 64'd0);
    chk("t6_lock_cleared", 64'(mem_addr), 64'h8000_0010);
    step(0, 1, 1, 0, 0);
    #2 chk("t6_data_aok", 64'(data_addr_ok), 64'd1);
    step(0, 0, 0, 1, 32'h77);
    #2;
    chk("t6_fifo_cleared", 64'(data_data_ok), 64'd1);
    chk("t6_data_rdata", 64'(data_rdata), 64'h77);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    #2 chk("t6_err_again", 64'(proto_err), 64'd1);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
